// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock measurement blocks.
//   meas_st_e   : measurement FSM state encoding (2 bits)
//   CNT_W_DEF   : default width of period/high/timeout counters
//   NPER_W_DEF  : default width of the period-count request
package clk_meas_pkg;
  localparam int CNT_W_DEF  = 16;
  localparam int NPER_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } meas_st_e;
endpackage

// File: rtl/clk_edge_sync.sv
// 3-flop synchronizer for an asynchronous level plus rising-edge detect.
// Ports:
//   clk    in  system clock
//   resetb in  async active-low reset
//   din    in  asynchronous input, sampled as data
//   lvl    out synchronized level (2nd flop)
//   rise   out 1-cycle pulse on a synchronized 0->1 transition
// lvl and rise share the same lag, so high-time and edge timing stay aligned.
module clk_edge_sync (
  input  logic clk,
  input  logic resetb,
  input  logic din,
  output logic lvl,
  output logic rise
);
  logic [2:0] sync_pipe;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) sync_pipe <= '0;
    else         sync_pipe <= {sync_pipe[1:0], din};
  end

  assign lvl  = sync_pipe[1];
  assign rise = sync_pipe[1] & ~sync_pipe[2];
endmodule

// File: rtl/clk_ratio_meter.sv
// Measures a monitored clock against clk: clk cycles across nper periods of
// mon_clk, and clk cycles mon_clk is high in the same window.
// Ports:
//   clk, resetb      system clock, async active-low reset
//   mon_clk          monitored clock (asynchronous, sampled as data)
//   start            request, accepted only when idle
//   nper             periods to measure (0 treated as 1)
//   timeout_lim      max clk cycles without a mon_clk rise (0 = disabled)
//   busy             measurement in progress (ARM/MEAS/DONE)
//   done             1-cycle completion pulse (normal end or timeout)
//   timeout          measurement ended by timeout
//   sat              a counter saturated
//   period_cnt       clk cycles across the measured periods
//   high_cnt         clk cycles mon_clk was high in the window
module clk_ratio_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NPER_W = NPER_W_DEF
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              mon_clk,
  input  logic              start,
  input  logic [NPER_W-1:0] nper,
  input  logic [CNT_W-1:0]  timeout_lim,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              sat,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt
);
  meas_st_e          state;
  logic [NPER_W-1:0] nper_eff;
  logic [NPER_W-1:0] per_left;
  logic [CNT_W-1:0]  gap;
  logic              lvl, rise;
  logic              to_hit;

  clk_edge_sync u_sync (
    .clk    (clk),
    .resetb (resetb),
    .din    (mon_clk),
    .lvl    (lvl),
    .rise   (rise)
  );

  // gap counts cycles since ARM entry or the last rise; firing at lim-1
  // puts done exactly lim cycles after the last reference point.
  assign to_hit = (timeout_lim != '0) && (gap == timeout_lim - CNT_W'(1));
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      nper_eff   <= '0;
      per_left   <= '0;
      gap        <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      sat        <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_ARM;
            period_cnt <= '0;
            high_cnt   <= '0;
            timeout    <= 1'b0;
            sat        <= 1'b0;
            gap        <= '0;
            nper_eff   <= (nper == '0) ? NPER_W'(1) : nper;
          end
        end
        ST_ARM: begin
          gap <= gap + CNT_W'(1);
          // First rise opens the window; that cycle itself is not counted.
          if (rise) begin
            state    <= ST_MEAS;
            per_left <= nper_eff;
            gap      <= '0;
          end else if (to_hit) begin
            state   <= ST_DONE;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end
        ST_MEAS: begin
          if (&period_cnt) sat <= 1'b1;
          else             period_cnt <= period_cnt + CNT_W'(1);
          if (lvl) begin
            if (&high_cnt) sat <= 1'b1;
            else           high_cnt <= high_cnt + CNT_W'(1);
          end
          gap <= rise ? '0 : gap + CNT_W'(1);
          if (rise) begin
            per_left <= per_left - NPER_W'(1);
            // Closing rise is counted above, giving a (t0, tk] window.
            if (per_left == NPER_W'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else if (to_hit) begin
            state   <= ST_DONE;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_ratio_meter.sv
module tb_clk_ratio_meter;
  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        mon_clk = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  nper = '0;
  logic [15:0] tlim = '0;
  logic [7:0]  tlim8 = '0;

  logic        busy, done, timeout, sat;
  logic [15:0] period_cnt, high_cnt;
  logic        busy8, done8, timeout8, sat8;
  logic [7:0]  period_cnt8, high_cnt8;

  clk_ratio_meter #(.CNT_W(16), .NPER_W(4)) dut (
    .clk(clk), .resetb(resetb), .mon_clk(mon_clk), .start(start), .nper(nper),
    .timeout_lim(tlim), .busy(busy), .done(done), .timeout(timeout), .sat(sat),
    .period_cnt(period_cnt), .high_cnt(high_cnt)
  );

  clk_ratio_meter #(.CNT_W(8), .NPER_W(4)) dut8 (
    .clk(clk), .resetb(resetb), .mon_clk(mon_clk), .start(start), .nper(nper),
    .timeout_lim(tlim8), .busy(busy8), .done(done8), .timeout(timeout8), .sat(sat8),
    .period_cnt(period_cnt8), .high_cnt(high_cnt8)
  );

  always #5 clk = ~clk;

  // mon_clk generator: period gen_div clk cycles, high for gen_hi of them.
  int gen_div = 6, gen_hi = 3;
  bit gen_en = 1'b0;
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      if (phase >= gen_div - 1) phase = 0;
      else                      phase++;
      mon_clk = gen_en && (phase < gen_hi);
    end
  end

  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, done8_cnt = 0;

  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (done8) done8_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_mon(input int div, input int hi, input bit en);
    gen_div = div;
    gen_hi  = hi;
    gen_en  = en;
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [3:0] n);
    @(negedge clk);
    nper  = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit use8, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(use8 ? done8 : done) && cyc < limit);
    if (!(use8 ? done8 : done)) chk("done_wait", use8 ? done8 : done, 1);
  endtask

  initial begin
    int cyc, d0, d8;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_sat", sat, 0);
    chk("rst_period", period_cnt, 0);
    chk("rst_high", high_cnt, 0);
    resetb = 1'b1;

    // clk/6, 3 high, nper=4
    set_mon(6, 3, 1);
    d0 = done_cnt;
    pulse_start(4'd4);
    wait_done(0, 500, cyc);
    chk("div6_period", period_cnt, 24);
    chk("div6_high", high_cnt, 12);
    chk("div6_timeout", timeout, 0);
    chk("div6_sat", sat, 0);
    repeat (3) @(negedge clk);
    chk("div6_done_once", done_cnt - d0, 1);
    chk("div6_idle", busy, 0);

    // clk/5, 2 high, nper=2
    set_mon(5, 2, 1);
    pulse_start(4'd2);
    wait_done(0, 500, cyc);
    chk("div5_period", period_cnt, 10);
    chk("div5_high", high_cnt, 4);

    // mon_clk stuck low: timeout 100 cycles after ARM entry
    set_mon(6, 3, 0);
    tlim = 16'd100;
    pulse_start(4'd1);
    wait_done(0, 500, cyc);
    chk("to_latency", cyc, 100);
    chk("to_flag", timeout, 1);
    chk("to_period", period_cnt, 0);
    chk("to_high", high_cnt, 0);
    tlim = '0;
    repeat (3) @(negedge clk);

    // nper=0 -> 1 period; start while busy and during DONE ignored
    set_mon(8, 4, 1);
    d0 = done_cnt;
    pulse_start(4'd0);
    repeat (3) @(negedge clk);
    chk("n0_busy", busy, 1);
    pulse_start(4'd5);
    wait_done(0, 500, cyc);
    chk("n0_period", period_cnt, 8);
    chk("n0_high", high_cnt, 4);
    chk("n0_timeout_clr", timeout, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("n0_done_start_ign", busy, 0);
    repeat (3) @(negedge clk);
    chk("n0_still_idle", busy, 0);
    chk("n0_done_once", done_cnt - d0, 1);

    // 8-bit counters saturate: clk/100, nper=4
    set_mon(100, 50, 1);
    d8 = done8_cnt;
    pulse_start(4'd4);
    wait_done(1, 2000, cyc);
    chk("sat_period", period_cnt8, 255);
    chk("sat_high", high_cnt8, 200);
    chk("sat_flag", sat8, 1);
    chk("sat_timeout", timeout8, 0);
    repeat (3) @(negedge clk);
    chk("sat_done_once", done8_cnt - d8, 1);
    repeat (40) @(negedge clk);

    // Reset mid-measurement
    set_mon(6, 3, 1);
    pulse_start(4'd4);
    repeat (15) @(negedge clk);
    chk("mid_busy", busy, 1);
    d0 = done_cnt;
    resetb = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_period", period_cnt, 0);
    chk("mid_rst_high", high_cnt, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_idle", busy, 0);
    pulse_start(4'd4);
    wait_done(0, 500, cyc);
    chk("post_rst_period", period_cnt, 24);
    chk("post_rst_high", high_cnt, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
